// File: rtl/jpeg_ctrl_pkg.sv
// Shared definitions for the JPEG encoder control path.
// Holds the sequencer state encoding, the component and quantizer-table codes,
// the default SRAM address width, and the component stepping helper.
package jpeg_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CC_RUN   = 3'd1,
    ST_DCT_RUN  = 3'd2,
    ST_QUAN_RUN = 3'd3,
    ST_HANDOFF  = 3'd4,
    ST_DONE     = 3'd5,
    ST_ERR      = 3'd6
  } seq_state_t;

  localparam logic [1:0] COMP_Y  = 2'd0;
  localparam logic [1:0] COMP_CB = 2'd1;
  localparam logic [1:0] COMP_CR = 2'd2;

  localparam logic QMODE_LUMA   = 1'b0;
  localparam logic QMODE_CHROMA = 1'b1;

  localparam int DEF_ADDR_W = 11;

  // Y -> Cb -> Cr -> Y
  function automatic logic [1:0] next_comp(input logic [1:0] c);
    case (c)
      COMP_Y:  return COMP_CB;
      COMP_CB: return COMP_CR;
      default: return COMP_Y;
    endcase
  endfunction

endpackage

// File: rtl/jpeg_watchdog.sv
// Purpose: stage watchdog; flags a stage that waits TIMEOUT cycles for its valid.
// Latency: expire is combinational from the count, high in the TIMEOUT-th waiting cycle.
// Backpressure: none; the owner decides which states are timed via en/clr.
// Ports: clk/rst (async, active-high); clr reloads the count; en counts one
//        waiting cycle; expire = en while no waiting cycles remain.
module jpeg_watchdog #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int LOAD_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] LOAD = LOAD_I[CNT_W-1:0];

  // Counts remaining cycles down from TIMEOUT-1, so the loaded value means
  // "zero cycles elapsed"; reset therefore loads it too.
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= LOAD;
    end else if (clr) begin
      cnt <= LOAD;
    end else if (en && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // TIMEOUT == 0 disables the trap entirely.
  assign expire = (TIMEOUT != 0) && en && (cnt == '0);

endmodule

// File: rtl/jpeg_block_sequencer.sv
// Purpose: frame sequencer: colour conversion once, then DCT/quant/entropy per block and component.
// Latency: all outputs but sram_raddr registered; an awaited valid swaps enables on the next cycle.
// Backpressure: HANDOFF holds ent_valid and indices until ent_ready, with no time limit.
// Ports: start; cc/dct/quan enable+valid pairs; cc_raddr/dct_raddr muxed onto
//        sram_raddr; ent_valid/ent_ready; blk_idx, comp_idx, quan_mode; busy, done, err.
module jpeg_block_sequencer
  import jpeg_ctrl_pkg::*;
#(
  parameter int  NUM_BLOCKS = 64,
  parameter int  TIMEOUT    = 4096,
  parameter int  ADDR_W     = DEF_ADDR_W,
  localparam int BLK_W      = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              cc_enable,
  input  logic              cc_valid,
  input  logic [ADDR_W-1:0] cc_raddr,
  output logic              dct_enable,
  input  logic              dct_valid,
  input  logic [ADDR_W-1:0] dct_raddr,
  output logic [ADDR_W-1:0] sram_raddr,
  output logic              quan_enable,
  output logic              quan_mode,
  input  logic              quan_valid,
  output logic              ent_valid,
  input  logic              ent_ready,
  output logic [BLK_W-1:0]  blk_idx,
  output logic [1:0]        comp_idx,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(NUM_BLOCKS - 1);

  seq_state_t state;
  logic       stage_valid;
  logic       wd_en;
  logic       wd_clr;
  logic       wd_expire;
  logic       last_unit;
  logic [1:0] comp_nxt;

  // The valid the current state is waiting for; only the run states are timed.
  always_comb begin
    stage_valid = 1'b0;
    wd_en       = 1'b0;
    case (state)
      ST_CC_RUN:   begin wd_en = 1'b1; stage_valid = cc_valid;   end
      ST_DCT_RUN:  begin wd_en = 1'b1; stage_valid = dct_valid;  end
      ST_QUAN_RUN: begin wd_en = 1'b1; stage_valid = quan_valid; end
      default:     ;
    endcase
  end

  // Every entry into a timed state comes either from an untimed state or from
  // an accepted valid, so holding clr in those cases restarts the count on entry.
  assign wd_clr = !wd_en || stage_valid;

  jpeg_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (wd_clr),
    .en     (wd_en),
    .expire (wd_expire)
  );

  assign last_unit  = (comp_idx == COMP_CR) && (blk_idx == LAST_BLK);
  assign comp_nxt   = next_comp(comp_idx);
  assign sram_raddr = (state == ST_CC_RUN) ? cc_raddr : dct_raddr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cc_enable   <= 1'b0;
      dct_enable  <= 1'b0;
      quan_enable <= 1'b0;
      quan_mode   <= QMODE_LUMA;
      ent_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      blk_idx     <= '0;
      comp_idx    <= COMP_Y;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_ERR: begin
          if (start) begin
            state     <= ST_CC_RUN;
            cc_enable <= 1'b1;
            busy      <= 1'b1;
            err       <= 1'b0;
            blk_idx   <= '0;
            comp_idx  <= COMP_Y;
            quan_mode <= QMODE_LUMA;
          end
        end
        // A valid on the expiry edge takes priority over the trap.
        ST_CC_RUN: begin
          if (cc_valid) begin
            state      <= ST_DCT_RUN;
            cc_enable  <= 1'b0;
            dct_enable <= 1'b1;
          end else if (wd_expire) begin
            state     <= ST_ERR;
            cc_enable <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b1;
          end
        end
        ST_DCT_RUN: begin
          if (dct_valid) begin
            state       <= ST_QUAN_RUN;
            dct_enable  <= 1'b0;
            quan_enable <= 1'b1;
          end else if (wd_expire) begin
            state      <= ST_ERR;
            dct_enable <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b1;
          end
        end
        ST_QUAN_RUN: begin
          if (quan_valid) begin
            state       <= ST_HANDOFF;
            quan_enable <= 1'b0;
            ent_valid   <= 1'b1;
          end else if (wd_expire) begin
            state       <= ST_ERR;
            quan_enable <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b1;
          end
        end
        // Indices and quan_mode only move here, so they stay fixed from
        // DCT_RUN entry through the handshake.
        ST_HANDOFF: begin
          if (ent_ready) begin
            ent_valid <= 1'b0;
            if (last_unit) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state      <= ST_DCT_RUN;
              dct_enable <= 1'b1;
              comp_idx   <= comp_nxt;
              quan_mode  <= (comp_nxt == COMP_Y) ? QMODE_LUMA : QMODE_CHROMA;
              if (comp_idx == COMP_CR) begin
                blk_idx <= blk_idx + BLK_W'(1);
              end
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jpeg_block_sequencer.sv
// Bench for jpeg_block_sequencer: instance A (2 blocks, timeout 8) checked every
// cycle against a behavioural model plus directed literal checks; instance B
// (1 block, watchdog off) checked for unbounded stalls and a 3-handshake frame.
module tb_jpeg_block_sequencer;

  localparam int A_NB = 2;
  localparam int A_TO = 8;
  localparam int P_IDLE = 0, P_CC = 1, P_DCT = 2, P_QUAN = 3, P_HAND = 4, P_DONE = 5, P_ERR = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_errs   = 0;

  // ---------------- instance A ----------------
  logic a_rst = 1'b1, a_start = 1'b0, a_ent_ready = 1'b1;
  logic a_cc_valid = 1'b0, a_dct_valid = 1'b0, a_quan_valid = 1'b0;
  logic [10:0] a_cc_raddr = 11'h155, a_dct_raddr = 11'h2AA, a_sram_raddr;
  logic a_cc_enable, a_dct_enable, a_quan_enable, a_quan_mode, a_ent_valid;
  logic a_busy, a_done, a_err;
  logic [0:0] a_blk_idx;
  logic [1:0] a_comp_idx;

  jpeg_block_sequencer #(.NUM_BLOCKS(A_NB), .TIMEOUT(A_TO), .ADDR_W(11)) u_a (
    .clk(clk), .rst(a_rst), .start(a_start),
    .cc_enable(a_cc_enable), .cc_valid(a_cc_valid), .cc_raddr(a_cc_raddr),
    .dct_enable(a_dct_enable), .dct_valid(a_dct_valid), .dct_raddr(a_dct_raddr),
    .sram_raddr(a_sram_raddr),
    .quan_enable(a_quan_enable), .quan_mode(a_quan_mode), .quan_valid(a_quan_valid),
    .ent_valid(a_ent_valid), .ent_ready(a_ent_ready),
    .blk_idx(a_blk_idx), .comp_idx(a_comp_idx),
    .busy(a_busy), .done(a_done), .err(a_err)
  );

  // ---------------- instance B ----------------
  logic b_rst = 1'b1, b_start = 1'b0, b_ent_ready = 1'b0;
  logic b_cc_valid = 1'b0, b_dct_valid = 1'b0, b_quan_valid = 1'b0;
  logic [10:0] b_cc_raddr = 11'h0F0, b_dct_raddr = 11'h00F, b_sram_raddr;
  logic b_cc_enable, b_dct_enable, b_quan_enable, b_quan_mode, b_ent_valid;
  logic b_busy, b_done, b_err;
  logic [0:0] b_blk_idx;
  logic [1:0] b_comp_idx;

  jpeg_block_sequencer #(.NUM_BLOCKS(1), .TIMEOUT(0), .ADDR_W(11)) u_b (
    .clk(clk), .rst(b_rst), .start(b_start),
    .cc_enable(b_cc_enable), .cc_valid(b_cc_valid), .cc_raddr(b_cc_raddr),
    .dct_enable(b_dct_enable), .dct_valid(b_dct_valid), .dct_raddr(b_dct_raddr),
    .sram_raddr(b_sram_raddr),
    .quan_enable(b_quan_enable), .quan_mode(b_quan_mode), .quan_valid(b_quan_valid),
    .ent_valid(b_ent_valid), .ent_ready(b_ent_ready),
    .blk_idx(b_blk_idx), .comp_idx(b_comp_idx),
    .busy(b_busy), .done(b_done), .err(b_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- stage responders for A ----------------
  // A stage raises valid once its enable has been high for *_dly cycles (0 = never).
  int cc_dly = 1, dct_dly = 1, quan_dly = 1, dct_stall_comp = -1;
  int cc_n = 0, dct_n = 0, quan_n = 0;
  always @(negedge clk) begin
    cc_n   = a_cc_enable   ? cc_n + 1   : 0;
    dct_n  = a_dct_enable  ? dct_n + 1  : 0;
    quan_n = a_quan_enable ? quan_n + 1 : 0;
    a_cc_valid   = a_cc_enable && cc_dly > 0 && cc_n >= cc_dly;
    a_dct_valid  = a_dct_enable && dct_dly > 0 && dct_n >= dct_dly &&
                   (int'(a_comp_idx) != dct_stall_comp);
    a_quan_valid = a_quan_enable && quan_dly > 0 && quan_n >= quan_dly;
  end

  // ---------------- behavioural model of A ----------------
  // Frame progress is a single unit counter t = 3*block + component; the
  // watchdog is an elapsed-cycle counter compared with TIMEOUT-1.
  int m_ph = P_IDLE, m_t = 0, m_wait = 0;
  always @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      m_ph = P_IDLE; m_t = 0; m_wait = 0;
    end else begin
      case (m_ph)
        P_IDLE, P_ERR: if (a_start) begin m_ph = P_CC; m_t = 0; m_wait = 0; end
        P_CC, P_DCT, P_QUAN: begin
          if ((m_ph == P_CC && a_cc_valid) || (m_ph == P_DCT && a_dct_valid) ||
              (m_ph == P_QUAN && a_quan_valid)) begin
            m_ph = m_ph + 1; m_wait = 0;
          end else if (A_TO != 0 && m_wait == A_TO - 1) begin
            m_ph = P_ERR;
          end else begin
            m_wait++;
          end
        end
        P_HAND: if (a_ent_ready) begin
          if (m_t == 3 * A_NB - 1) m_ph = P_DONE;
          else begin m_t++; m_ph = P_DCT; m_wait = 0; end
        end
        P_DONE: m_ph = P_IDLE;
        default: m_ph = P_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    check("cc_enable",   32'(a_cc_enable),   32'(m_ph == P_CC));
    check("dct_enable",  32'(a_dct_enable),  32'(m_ph == P_DCT));
    check("quan_enable", 32'(a_quan_enable), 32'(m_ph == P_QUAN));
    check("ent_valid",   32'(a_ent_valid),   32'(m_ph == P_HAND));
    check("busy",        32'(a_busy),        32'(m_ph >= P_CC && m_ph <= P_HAND));
    check("done",        32'(a_done),        32'(m_ph == P_DONE));
    check("err",         32'(a_err),         32'(m_ph == P_ERR));
    check("blk_idx",     32'(a_blk_idx),     m_t / 3);
    check("comp_idx",    32'(a_comp_idx),    m_t % 3);
    check("quan_mode",   32'(a_quan_mode),   32'((m_t % 3) != 0));
    check("sram_raddr",  32'(a_sram_raddr),  32'((m_ph == P_CC) ? a_cc_raddr : a_dct_raddr));
  end

  // ---------------- handshake and done loggers ----------------
  int hs_blk[$], hs_comp[$], hs_qm[$], b_hs[$];
  int done_cnt = 0, b_done_cnt = 0;
  always @(posedge clk) begin
    if (!a_rst && a_ent_valid && a_ent_ready) begin
      hs_blk.push_back(int'(a_blk_idx));
      hs_comp.push_back(int'(a_comp_idx));
      hs_qm.push_back(int'(a_quan_mode));
    end
    if (!b_rst && b_ent_valid && b_ent_ready) b_hs.push_back(int'(b_comp_idx));
  end
  always @(negedge clk) begin
    if (a_done) done_cnt++;
    if (b_done) b_done_cnt++;
  end

  function automatic logic cond(input int w);
    case (w)
      0: return a_dct_enable;
      1: return a_quan_enable;
      2: return a_err;
      3: return a_dct_enable && a_comp_idx == 2'd1;
      4: return a_quan_enable && a_blk_idx == 1'b1 && a_comp_idx == 2'd1;
      5: return a_quan_enable && a_comp_idx == 2'd1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_cond(input int w, input int bound, input string name);
    int i = 0;
    while (!cond(w) && i < bound) begin @(negedge clk); i++; end
    if (!cond(w)) check(name, 0, 1);
  endtask

  task automatic run_to_done(input int bound);
    int i = 0;
    while (!a_done && i < bound) begin @(negedge clk); i++; end
    check("done_reached", 32'(a_done), 1);
  endtask

  task automatic pulse_start();
    a_start = 1'b1; @(negedge clk); a_start = 1'b0;
  endtask

  int exp_blk[6]  = '{0, 0, 0, 1, 1, 1};
  int exp_comp[6] = '{0, 1, 2, 0, 1, 2};
  int exp_qm[6]   = '{0, 1, 1, 0, 1, 1};

  initial begin
    int t0, n, berr;
    repeat (2) @(negedge clk);
    // Reset state
    check("rst_cc_enable", 32'(a_cc_enable), 0);
    check("rst_dct_enable", 32'(a_dct_enable), 0);
    check("rst_quan_enable", 32'(a_quan_enable), 0);
    check("rst_quan_mode", 32'(a_quan_mode), 0);
    check("rst_ent_valid", 32'(a_ent_valid), 0);
    check("rst_busy", 32'(a_busy), 0);
    check("rst_done", 32'(a_done), 0);
    check("rst_err", 32'(a_err), 0);
    check("rst_blk_idx", 32'(a_blk_idx), 0);
    check("rst_comp_idx", 32'(a_comp_idx), 0);
    check("rst_sram_raddr", 32'(a_sram_raddr), 32'h2AA);
    check("rst_b_sram_raddr", 32'(b_sram_raddr), 32'h00F);
    a_rst = 1'b0; b_rst = 1'b0;
    @(negedge clk);

    // Frame 1: stages answer 3 cycles after enable; stray start while busy.
    cc_dly = 4; dct_dly = 4; quan_dly = 4;
    pulse_start();
    check("start_to_cc_enable", 32'(a_cc_enable), 1);
    check("cc_sram_raddr", 32'(a_sram_raddr), 32'h155);
    repeat (5) @(negedge clk);
    check("busy_mid_frame", 32'(a_busy), 1);
    pulse_start();
    run_to_done(500);
    check("busy_falls_with_done", 32'(a_busy), 0);
    repeat (3) @(negedge clk);
    check("done_pulses", done_cnt, 1);
    check("hs_count", hs_blk.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < hs_blk.size()) begin
        check($sformatf("hs_blk[%0d]", i), hs_blk[i], exp_blk[i]);
        check($sformatf("hs_comp[%0d]", i), hs_comp[i], exp_comp[i]);
        check($sformatf("hs_qm[%0d]", i), hs_qm[i], exp_qm[i]);
      end
    end

    // Frame 2: zero-wait stages give the minimum frame time 1 + 9*2 + 1.
    cc_dly = 1; dct_dly = 1; quan_dly = 1;
    pulse_start();
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (a_busy || a_done) n++;
      if (a_done) break;
      @(negedge clk);
    end
    check("min_frame_cycles", n, 20);
    @(negedge clk);

    // Frame 3: entropy backpressure on block 0 Cb longer than TIMEOUT.
    pulse_start();
    wait_cond(5, 50, "reach_cb_quan");
    a_ent_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_ent_valid", 32'(a_ent_valid), 1);
      check("stall_blk_idx", 32'(a_blk_idx), 0);
      check("stall_comp_idx", 32'(a_comp_idx), 1);
      check("stall_quan_mode", 32'(a_quan_mode), 1);
      check("stall_err", 32'(a_err), 0);
    end
    a_ent_ready = 1'b1;
    run_to_done(200);
    @(negedge clk);

    // Frame 4: DCT hangs on block 0 Cb -> ERR 8 cycles after DCT entry, then restart.
    dct_stall_comp = 1;
    pulse_start();
    wait_cond(3, 100, "reach_cb_dct");
    t0 = cyc;
    wait_cond(2, 50, "reach_err");
    check("err_latency", cyc - t0, 8);
    check("err_flag", 32'(a_err), 1);
    check("err_enables", {29'd0, a_cc_enable, a_dct_enable, a_quan_enable}, 0);
    check("err_ent_valid", 32'(a_ent_valid), 0);
    check("err_sram_raddr", 32'(a_sram_raddr), 32'h2AA);
    @(negedge clk);
    check("err_sticky", 32'(a_err), 1);
    dct_stall_comp = -1;
    pulse_start();
    check("restart_err_clear", 32'(a_err), 0);
    check("restart_cc_enable", 32'(a_cc_enable), 1);
    check("restart_idx", {29'd0, a_blk_idx, a_comp_idx}, 0);
    run_to_done(500);
    @(negedge clk);

    // Frame 5: dct_valid lands on the expiry cycle -> valid wins.
    dct_dly = 8;
    pulse_start();
    wait_cond(0, 50, "reach_dct");
    t0 = cyc;
    wait_cond(1, 50, "reach_quan");
    check("dct_at_expiry_cycles", cyc - t0, 8);
    check("dct_at_expiry_no_err", 32'(a_err), 0);
    run_to_done(500);
    check("frame5_no_err", 32'(a_err), 0);
    @(negedge clk);

    // Frame 6: asynchronous reset in the middle of block 1 Cb QUAN_RUN.
    dct_dly = 1; quan_dly = 4; done_cnt = 0;
    pulse_start();
    wait_cond(4, 200, "reach_blk1_cb_quan");
    #2 a_rst = 1'b1;
    #1;
    check("arst_outputs", {21'd0, a_cc_enable, a_dct_enable, a_quan_enable, a_quan_mode,
                           a_ent_valid, a_busy, a_done, a_err, a_blk_idx, a_comp_idx}, 0);
    check("arst_sram_raddr", 32'(a_sram_raddr), 32'h2AA);
    @(negedge clk);
    #2 a_rst = 1'b0;
    repeat (4) @(negedge clk);
    check("arst_no_done", done_cnt, 0);

    // Instance B: one block, watchdog disabled, long stall then free run.
    b_start = 1'b1; @(negedge clk); b_start = 1'b0;
    check("b_start_cc_enable", 32'(b_cc_enable), 1);
    berr = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (b_err) berr++;
    end
    check("b_stall_no_err", berr, 0);
    check("b_still_in_cc", 32'(b_cc_enable), 1);
    b_cc_valid = 1'b1; b_dct_valid = 1'b1; b_quan_valid = 1'b1; b_ent_ready = 1'b1;
    for (int i = 0; i < 50 && b_done_cnt == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("b_done_pulses", b_done_cnt, 1);
    check("b_hs_count", b_hs.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < b_hs.size()) check($sformatf("b_hs_comp[%0d]", i), b_hs[i], i);
    end
    check("b_idle_busy", 32'(b_busy), 0);
    check("b_final_err", 32'(b_err), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
